arm_multi_controller: RTL and testbench

- Control unit for the multicycle ARM core with unified instruction/data memory.
- Contains the main state machine, ALU decoder, instruction-field decoder, flags register and condition logic.
- Drives every mux select and write enable of the multicycle datapath, one state per clock.
- Sits in the core beside the datapath. The datapath supplies the latched instruction and the ALU flags.

---
 rtl/arm_multi_controller.sv | 172 +++++++++++++++++
 tb/tb_arm_multi_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multi_controller.sv
// Control unit for the multicycle ARM core: main FSM, ALU decoder, condition
// logic and NZCV flags register, driving every datapath select and enable.
module arm_multi_controller #(
    parameter bit         COND_NV_EXEC = 1'b0,
    parameter logic [3:0] FLAGS_RESET  = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_flags;
    logic        r_condex;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_nextpc, w_branch, w_regw, w_memw, w_irw, w_aluop;
    logic        w_condex;
    logic [1:0]  w_flagw;

    assign w_cond  = Instr[11:8];
    assign w_op    = Instr[7:6];
    assign w_funct = Instr[5:0];

    // Flags are {N, Z, C, V}
    function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_ex = z;
            4'h1:    cond_ex = ~z;
            4'h2:    cond_ex = cy;
            4'h3:    cond_ex = ~cy;
            4'h4:    cond_ex = n;
            4'h5:    cond_ex = ~n;
            4'h6:    cond_ex = v;
            4'h7:    cond_ex = ~v;
            4'h8:    cond_ex = cy & ~z;
            4'h9:    cond_ex = ~cy | z;
            4'hA:    cond_ex = (n == v);
            4'hB:    cond_ex = (n != v);
            4'hC:    cond_ex = ~z & (n == v);
            4'hD:    cond_ex = z | (n != v);
            4'hE:    cond_ex = 1'b1;
            default: cond_ex = COND_NV_EXEC;
        endcase
    endfunction

    assign w_condex = cond_ex(w_cond, r_flags);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_nextpc  = 1'b0;
        w_branch  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_irw     = 1'b0;
        w_aluop   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irw = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
                ResultSrc = 2'b10; w_nextpc = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMRD:    AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; w_regw = 1'b1; end
            S_MEMWR:    begin AdrSrc = 1'b1; w_memw = 1'b1; end
            S_EXECUTER: w_aluop = 1'b1;
            S_EXECUTEI: begin ALUSrcB = 2'b01; w_aluop = 1'b1; end
            S_ALUWB:    w_regw = 1'b1;
            S_BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; w_branch = 1'b1; end
            default:    ;
        endcase
    end

    // Unrecognised data-processing encodings fall back to ADD without touching flags
    always_comb begin
        ALUControl = 2'b00;
        w_flagw    = 2'b00;
        if (w_aluop) begin
            case (w_funct[4:1])
                4'b0100: begin ALUControl = 2'b00; w_flagw = {w_funct[0], w_funct[0]}; end
                4'b0010: begin ALUControl = 2'b01; w_flagw = {w_funct[0], w_funct[0]}; end
                4'b0000: begin ALUControl = 2'b10; w_flagw = {w_funct[0], 1'b0}; end
                4'b1100: begin ALUControl = 2'b11; w_flagw = {w_funct[0], 1'b0}; end
                default: begin ALUControl = 2'b00; w_flagw = 2'b00; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags  <= FLAGS_RESET;
            r_condex <= 1'b0;
        end else begin
            if (r_state == S_DECODE)
                r_condex <= w_condex;
            if ((r_state == S_EXECUTER || r_state == S_EXECUTEI) && r_condex) begin
                if (w_flagw[1]) r_flags[3:2] <= ALUFlags[3:2];
                if (w_flagw[0]) r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign PCWrite  = ~reset & (w_nextpc | (w_branch & r_condex));
    assign RegWrite = ~reset & w_regw & r_condex;
    assign MemWrite = ~reset & w_memw & r_condex;
    assign IRWrite  = ~reset & w_irw;
    assign RegSrc   = {(w_op == 2'b01), (w_op == 2'b10)};
    assign ImmSrc   = w_op;
    assign State    = r_state;

endmodule

// File: tb/tb_arm_multi_controller.sv
// Bench for arm_multi_controller: directed cycle table, hand-written corner
// sequences, then random instructions checked against an instruction-level model.
module tb_arm_multi_controller;

    logic        clk, reset;
    logic [11:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  State;

    arm_multi_controller #(.COND_NV_EXEC(1'b0), .FLAGS_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic [3:0] m_flags;

    typedef struct {
        logic        rst;
        logic [11:0] ins;
        logic [3:0]  st;
        logic        pcw, memw, regw, irw, adr;
        logic [1:0]  rsrc, aluc, rgs;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hc(input string tag, input logic [3:0] st, input logic pcw,
                      input logic memw, input logic regw, input logic [1:0] aluc);
        @(negedge clk);
        chk({tag, "_state"}, State, st);
        chk({tag, "_pcw"}, PCWrite, pcw);
        chk({tag, "_memw"}, MemWrite, memw);
        chk({tag, "_regw"}, RegWrite, regw);
        chk({tag, "_aluc"}, ALUControl, aluc);
        tick();
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;          1: return !z;
            2: return cy;         3: return !cy;
            4: return n;          5: return !n;
            6: return v;          7: return !v;
            8: return cy && !z;   9: return !cy || z;
            10: return n == v;    11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level reference: state path, enables per cycle, then flag effect
    task automatic run_model(input logic [11:0] ins);
        logic [1:0] op;
        logic [5:0] fn;
        logic       pass, ls_load, last, legal, addsub;
        logic [3:0] seq[5];
        logic [3:0] used;
        logic [1:0] exp_alu;
        int n;
        op = ins[7:6];
        fn = ins[5:0];
        pass = cond_ok(ins[11:8], m_flags);
        ls_load = fn[0];
        used = 4'h0;
        seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 0; seq[4] = 0;
        case (op)
            2'b00: begin n = 4; seq[2] = fn[5] ? 4'd7 : 4'd6; seq[3] = 8; end
            2'b01: begin
                seq[2] = 2;
                if (ls_load) begin n = 5; seq[3] = 3; seq[4] = 4; end
                else begin n = 4; seq[3] = 5; end
            end
            2'b10: begin n = 3; seq[2] = 9; end
            default: n = 2;
        endcase
        legal  = (fn[4:1] == 4'b0100) || (fn[4:1] == 4'b0010) ||
                 (fn[4:1] == 4'b0000) || (fn[4:1] == 4'b1100);
        addsub = (fn[4:1] == 4'b0100) || (fn[4:1] == 4'b0010);
        case (fn[4:1])
            4'b0010: exp_alu = 2'b01;
            4'b0000: exp_alu = 2'b10;
            4'b1100: exp_alu = 2'b11;
            default: exp_alu = 2'b00;
        endcase
        Instr = ins;
        for (int i = 0; i < n; i++) begin
            ALUFlags = 4'($urandom);
            last = (i == n - 1);
            @(negedge clk);
            chk("rnd_state", State, seq[i]);
            chk("rnd_pcw", PCWrite, (i == 0) || (op == 2'b10 && i == 2 && pass));
            chk("rnd_irw", IRWrite, i == 0);
            chk("rnd_regw", RegWrite, pass && last && (op == 2'b00 || (op == 2'b01 && ls_load)));
            chk("rnd_memw", MemWrite, pass && last && op == 2'b01 && !ls_load);
            if (op == 2'b00 && i == 2) begin
                chk("rnd_aluc", ALUControl, exp_alu);
                used = ALUFlags;
            end
            tick();
        end
        if (op == 2'b00 && pass && fn[0] && legal) begin
            m_flags[3:2] = used[3:2];
            if (addsub) m_flags[1:0] = used[1:0];
        end
    endtask

    initial begin
        //          rst   ins      st  pcw memw regw irw adr rsrc   aluc   rgs
        tbl[0]  = '{1'b1, 12'hE28, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00};
        tbl[1]  = '{1'b1, 12'hE28, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00};
        tbl[2]  = '{1'b0, 12'hE28, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00};
        tbl[3]  = '{1'b0, 12'hE28, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00};
        tbl[4]  = '{1'b0, 12'hE28, 7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[5]  = '{1'b0, 12'hE28, 8, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{1'b0, 12'hE59, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10};
        tbl[7]  = '{1'b0, 12'hE59, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10};
        tbl[8]  = '{1'b0, 12'hE59, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10};
        tbl[9]  = '{1'b0, 12'hE59, 3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10};
        tbl[10] = '{1'b0, 12'hE59, 4, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b10};
        tbl[11] = '{1'b0, 12'hE58, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10};
        tbl[12] = '{1'b0, 12'hE58, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10};
        tbl[13] = '{1'b0, 12'hE58, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10};
        tbl[14] = '{1'b0, 12'hE58, 5, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b10};

        reset = 1'b1; Instr = 12'hE28; ALUFlags = 4'h0;
        tick();
        for (int i = 0; i < 15; i++) begin
            reset = tbl[i].rst;
            Instr = tbl[i].ins;
            @(negedge clk);
            chk($sformatf("tbl%0d_state", i), State, tbl[i].st);
            chk($sformatf("tbl%0d_pcw", i), PCWrite, tbl[i].pcw);
            chk($sformatf("tbl%0d_memw", i), MemWrite, tbl[i].memw);
            chk($sformatf("tbl%0d_regw", i), RegWrite, tbl[i].regw);
            chk($sformatf("tbl%0d_irw", i), IRWrite, tbl[i].irw);
            chk($sformatf("tbl%0d_adr", i), AdrSrc, tbl[i].adr);
            chk($sformatf("tbl%0d_rsrc", i), ResultSrc, tbl[i].rsrc);
            chk($sformatf("tbl%0d_aluc", i), ALUControl, tbl[i].aluc);
            chk($sformatf("tbl%0d_regsrc", i), RegSrc, tbl[i].rgs);
            tick();
        end

        // SUBS setting Z, then BEQ taken
        Instr = 12'hE25; ALUFlags = 4'b0100;
        hc("subs_f", 0, 1, 0, 0, 2'b00);
        hc("subs_d", 1, 0, 0, 0, 2'b00);
        hc("subs_x", 7, 0, 0, 0, 2'b01);
        hc("subs_w", 8, 0, 0, 1, 2'b00);
        Instr = 12'h0A0; ALUFlags = 4'b0000;
        #1;
        chk("beq_regsrc", RegSrc, 2'b01);
        chk("beq_immsrc", ImmSrc, 2'b10);
        hc("beq_f", 0, 1, 0, 0, 2'b00);
        hc("beq_d", 1, 0, 0, 0, 2'b00);
        hc("beq_b", 9, 1, 0, 0, 2'b00);
        // Clear Z, then BEQ not taken and ADDEQ suppressed
        Instr = 12'hE25; ALUFlags = 4'b0000;
        hc("subs0_f", 0, 1, 0, 0, 2'b00);
        hc("subs0_d", 1, 0, 0, 0, 2'b00);
        hc("subs0_x", 7, 0, 0, 0, 2'b01);
        hc("subs0_w", 8, 0, 0, 1, 2'b00);
        Instr = 12'h0A0; ALUFlags = 4'b0100;
        hc("bne_f", 0, 1, 0, 0, 2'b00);
        hc("bne_d", 1, 0, 0, 0, 2'b00);
        hc("bne_b", 9, 0, 0, 0, 2'b00);
        Instr = 12'h028;
        hc("addeq_f", 0, 1, 0, 0, 2'b00);
        hc("addeq_d", 1, 0, 0, 0, 2'b00);
        hc("addeq_x", 7, 0, 0, 0, 2'b00);
        hc("addeq_w", 8, 0, 0, 0, 2'b00);
        // Undefined op, then reset landing on MEMWR
        Instr = 12'hEC0;
        hc("undef_f", 0, 1, 0, 0, 2'b00);
        hc("undef_d", 1, 0, 0, 0, 2'b00);
        Instr = 12'hE58;
        hc("strr_f", 0, 1, 0, 0, 2'b00);
        hc("strr_d", 1, 0, 0, 0, 2'b00);
        hc("strr_a", 2, 0, 0, 0, 2'b00);
        reset = 1'b1;
        hc("strr_rst", 5, 0, 0, 0, 2'b00);
        reset = 1'b0;
        hc("strr_f2", 0, 1, 0, 0, 2'b00);
        hc("strr_d2", 1, 0, 0, 0, 2'b00);
        hc("strr_a2", 2, 0, 0, 0, 2'b00);
        hc("strr_w2", 5, 0, 1, 0, 2'b00);
        m_flags = 4'b0000;

        for (int k = 0; k < 200; k++)
            run_model(12'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
